// File: rtl/mmu_pkg.sv
// Shared types and constants for the TLB/MMU block: exception codes,
// access-type and FSM-state enums, the TLB entry layout and small
// helpers for the permission and misalignment checks.
package mmu_pkg;

  // Entry fields are sized for the widest supported address; each module
  // casts down to its own VPN/PPN width, and unused upper bits stay zero.
  localparam int TLB_MAX_VPN_W = 64;
  localparam int TLB_MAX_PPN_W = 64;

  localparam logic [7:0] EXC_NONE    = 8'd0;
  localparam logic [7:0] LD_MISALIGN = 8'd4;
  localparam logic [7:0] ST_MISALIGN = 8'd6;
  localparam logic [7:0] INST_PF     = 8'd12;
  localparam logic [7:0] LD_PF       = 8'd13;
  localparam logic [7:0] ST_PF       = 8'd15;

  typedef enum logic [1:0] {
    ACC_LD   = 2'd0,
    ACC_ST   = 2'd1,
    ACC_INST = 2'd2
  } acc_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RESP = 2'd2
  } mmu_state_t;

  typedef struct packed {
    logic                     valid;
    logic [TLB_MAX_VPN_W-1:0] vpn;
    logic [TLB_MAX_PPN_W-1:0] ppn;
    logic                     x;
    logic                     w;
    logic                     r;
  } tlb_entry_t;

  // perm is {X, W, R}; the undefined type encoding 3 is treated as a fetch.
  function automatic logic perm_ok(input logic [1:0] acc, input logic [2:0] perm);
    case (acc_type_t'(acc))
      ACC_LD:  return perm[0];
      ACC_ST:  return perm[1];
      default: return perm[2];
    endcase
  endfunction

  function automatic logic [7:0] pf_code(input logic [1:0] acc);
    case (acc_type_t'(acc))
      ACC_LD:  return LD_PF;
      ACC_ST:  return ST_PF;
      default: return INST_PF;
    endcase
  endfunction

  function automatic logic [7:0] misalign_code(input logic [1:0] acc);
    case (acc_type_t'(acc))
      ACC_LD:  return LD_MISALIGN;
      ACC_ST:  return ST_MISALIGN;
      default: return EXC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative TLB storage: entry array, parallel VPN match,
// victim selection (lowest invalid entry, else round-robin pointer)
// and the flush clear. Flush wins over a fill in the same cycle.
module tlb_cam
  import mmu_pkg::*;
#(
  parameter int VPN_W       = 20,
  parameter int PPN_W       = 20,
  parameter int NUM_ENTRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VPN_W-1:0] lookup_vpn_i,
  output logic             hit_o,
  output logic [PPN_W-1:0] hit_ppn_o,
  output logic [2:0]       hit_perm_o,
  input  logic             flush_i,
  input  logic             fill_en_i,
  input  logic [VPN_W-1:0] fill_vpn_i,
  input  logic [PPN_W-1:0] fill_ppn_i,
  input  logic [2:0]       fill_perm_i
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  tlb_entry_t       r_entries [NUM_ENTRIES];
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_victim;
  tlb_entry_t       w_fill_entry;

  // Parallel match; fills never duplicate a VPN, so at most one entry hits.
  always_comb begin
    hit_o      = 1'b0;
    hit_ppn_o  = '0;
    hit_perm_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_entries[i].valid && (r_entries[i].vpn == TLB_MAX_VPN_W'(lookup_vpn_i))) begin
        hit_o      = 1'b1;
        hit_ppn_o  = PPN_W'(r_entries[i].ppn);
        hit_perm_o = {r_entries[i].x, r_entries[i].w, r_entries[i].r};
      end
    end
  end

  // Victim: scan downwards so the lowest-index invalid entry wins.
  always_comb begin
    w_victim = r_rr_ptr;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_entries[i].valid) w_victim = IDX_W'(i);
    end
  end

  // Assemble the entry written on a fill.
  always_comb begin
    w_fill_entry       = '0;
    w_fill_entry.valid = 1'b1;
    w_fill_entry.vpn   = TLB_MAX_VPN_W'(fill_vpn_i);
    w_fill_entry.ppn   = TLB_MAX_PPN_W'(fill_ppn_i);
    w_fill_entry.x     = fill_perm_i[2];
    w_fill_entry.w     = fill_perm_i[1];
    w_fill_entry.r     = fill_perm_i[0];
  end

  // Entry array update: flush clears valid bits; a fill writes the victim
  // and always advances the round-robin pointer (wraps naturally).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_entries[i] <= '0;
      r_rr_ptr <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_entries[i].valid <= 1'b0;
    end else if (fill_en_i) begin
      r_entries[w_victim] <= w_fill_entry;
      r_rr_ptr            <= r_rr_ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tlb_mmu.sv
// TLB-based MMU: one translation per cycle on a hit, misalignment and
// permission checks, and an IDLE/WALK/RESP FSM driving an external
// page-table walker on a miss.
// Optional feature: define TLB_PERF_COUNTERS_EN to add hit/miss counters.
//
// Handshakes: a request is accepted when req_valid_i && req_ready_o at a
// rising edge; resp_valid_o is a one-cycle strobe with no backpressure;
// ptw_req_o stays high until the cycle ptw_ack_i is seen in WALK.
module tlb_mmu
  import mmu_pkg::*;
#(
  parameter int VADDR_W       = 32,
  parameter int PADDR_W       = 32,
  parameter int PAGE_OFFSET_W = 12,
  parameter int NUM_ENTRIES   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [VADDR_W-1:0]         req_vaddr_i,
  input  logic [1:0]                 req_size_i,
  input  logic [1:0]                 req_type_i,
  output logic                       resp_valid_o,
  output logic [PADDR_W-1:0]         resp_paddr_o,
  output logic [7:0]                 exception_o,
  input  logic                       flush_i,
  output logic                       ptw_req_o,
  output logic [VADDR_W-PAGE_OFFSET_W-1:0] ptw_vpn_o,
  input  logic                       ptw_ack_i,
  input  logic [PADDR_W-PAGE_OFFSET_W-1:0] ptw_ppn_i,
  input  logic [2:0]                 ptw_perm_i,
  input  logic                       ptw_fault_i,
`ifdef TLB_PERF_COUNTERS_EN
  output logic [31:0]                hit_count_o,
  output logic [31:0]                miss_count_o,
`endif
  output mmu_state_t                 dbg_state_o
);

  localparam int VPN_W = VADDR_W - PAGE_OFFSET_W;
  localparam int PPN_W = PADDR_W - PAGE_OFFSET_W;

  mmu_state_t               r_state;
  mmu_state_t               w_state_next;
  logic                     r_resp_valid;
  logic [PADDR_W-1:0]       r_resp_paddr;
  logic [7:0]               r_exc;
  logic [VPN_W-1:0]         r_walk_vpn;
  logic [1:0]               r_walk_type;
  logic [PAGE_OFFSET_W-1:0] r_walk_off;
  logic                     r_fill_kill;

  logic [VPN_W-1:0]         w_vpn;
  logic [PAGE_OFFSET_W-1:0] w_off;
  logic [2:0]               w_align_mask;
  logic                     w_misalign;
  logic                     w_accept;
  logic                     w_cam_hit;
  logic [PPN_W-1:0]         w_cam_ppn;
  logic [2:0]               w_cam_perm;
  logic                     w_fill_en;

  assign w_vpn    = req_vaddr_i[VADDR_W-1:PAGE_OFFSET_W];
  assign w_off    = req_vaddr_i[PAGE_OFFSET_W-1:0];
  assign w_accept = req_valid_i && req_ready_o;

  // Low-address mask for the access size; fetches are never alignment-checked.
  always_comb begin
    case (req_size_i)
      2'd0:    w_align_mask = 3'b000;
      2'd1:    w_align_mask = 3'b001;
      2'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_misalign = !req_type_i[1] && (|(req_vaddr_i[2:0] & w_align_mask));

  // A flush anywhere in WALK (including the ack cycle) suppresses the fill.
  assign w_fill_en = (r_state == ST_WALK) && ptw_ack_i && !ptw_fault_i &&
                     !r_fill_kill && !flush_i;

  tlb_cam #(
    .VPN_W       (VPN_W),
    .PPN_W       (PPN_W),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_cam (
    .clk          (clk),
    .reset        (reset),
    .lookup_vpn_i (w_vpn),
    .hit_o        (w_cam_hit),
    .hit_ppn_o    (w_cam_ppn),
    .hit_perm_o   (w_cam_perm),
    .flush_i      (flush_i),
    .fill_en_i    (w_fill_en),
    .fill_vpn_i   (r_walk_vpn),
    .fill_ppn_i   (ptw_ppn_i),
    .fill_perm_i  (ptw_perm_i)
  );

  // FSM state register; reset drops ptw_req_o asynchronously via IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    ptw_req_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !w_misalign && !w_cam_hit) w_state_next = ST_WALK;
      end
      ST_WALK: begin
        ptw_req_o = 1'b1;
        if (ptw_ack_i) w_state_next = ST_RESP;
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Response register and walk context; outputs are zero outside a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_exc        <= EXC_NONE;
      r_walk_vpn   <= '0;
      r_walk_type  <= '0;
      r_walk_off   <= '0;
      r_fill_kill  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_exc        <= EXC_NONE;
      if (w_accept) begin
        if (w_misalign) begin
          r_resp_valid <= 1'b1;
          r_exc        <= misalign_code(req_type_i);
        end else if (w_cam_hit) begin
          r_resp_valid <= 1'b1;
          if (perm_ok(req_type_i, w_cam_perm)) r_resp_paddr <= {w_cam_ppn, w_off};
          else                                 r_exc        <= pf_code(req_type_i);
        end else begin
          r_walk_vpn  <= w_vpn;
          r_walk_type <= req_type_i;
          r_walk_off  <= w_off;
          r_fill_kill <= 1'b0;
        end
      end
      if (r_state == ST_WALK) begin
        if (flush_i) r_fill_kill <= 1'b1;
        if (ptw_ack_i) begin
          r_resp_valid <= 1'b1;
          if (!ptw_fault_i && perm_ok(r_walk_type, ptw_perm_i))
            r_resp_paddr <= {ptw_ppn_i, r_walk_off};
          else
            r_exc <= pf_code(r_walk_type);
        end
      end
    end
  end

`ifdef TLB_PERF_COUNTERS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Accepted hit/miss counters; misaligned requests count as neither.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept && !w_misalign) begin
      if (w_cam_hit) r_hit_count  <= r_hit_count + 32'd1;
      else           r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count_o  = r_hit_count;
  assign miss_count_o = r_miss_count;
`endif

  assign resp_valid_o = r_resp_valid;
  assign resp_paddr_o = r_resp_paddr;
  assign exception_o  = r_exc;
  assign ptw_vpn_o    = r_walk_vpn;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: cold miss, hits, permission faults,
// misalignment, walker faults, replacement, flush and reset mid-walk.
module tb_tlb_mmu;
  import mmu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_size;
  logic [1:0]  req_type;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic [7:0]  exc;
  logic        flush;
  logic        ptw_req;
  logic [19:0] ptw_vpn;
  logic        ptw_ack;
  logic [19:0] ptw_ppn;
  logic [2:0]  ptw_perm;
  logic        ptw_fault;
  mmu_state_t  dbg_state;
`ifdef TLB_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_total;
  int n_bad;
  int exp_hits;
  int exp_misses;

  tlb_mmu dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_vaddr_i  (req_vaddr),
    .req_size_i   (req_size),
    .req_type_i   (req_type),
    .resp_valid_o (resp_valid),
    .resp_paddr_o (resp_paddr),
    .exception_o  (exc),
    .flush_i      (flush),
    .ptw_req_o    (ptw_req),
    .ptw_vpn_o    (ptw_vpn),
    .ptw_ack_i    (ptw_ack),
    .ptw_ppn_i    (ptw_ppn),
    .ptw_perm_i   (ptw_perm),
    .ptw_fault_i  (ptw_fault),
`ifdef TLB_PERF_COUNTERS_EN
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_req(input logic [31:0] va, input logic [1:0] ty, input logic [1:0] sz);
    req_valid = 1'b1;
    req_vaddr = va;
    req_type  = ty;
    req_size  = sz;
  endtask

  // Miss: ack is held high in the acceptance cycle (must be ignored), one
  // idle WALK cycle (optionally with flush), then the real ack.
  task automatic do_miss(input string tag, input logic [31:0] va, input logic [1:0] ty,
                         input logic [1:0] sz, input logic [19:0] ppn, input logic [2:0] perm,
                         input logic fault, input logic flush_mid,
                         input logic [31:0] exp_pa, input logic [7:0] exp_exc);
    drive_req(va, ty, sz);
    ptw_ack   = 1'b1;
    ptw_ppn   = 20'hFFFFF;
    ptw_perm  = 3'b111;
    ptw_fault = 1'b0;
    exp_misses++;
    tick();
    chk({tag, " ptw_req rise"}, 64'(ptw_req), 64'd1);
    chk({tag, " ptw_vpn"}, 64'(ptw_vpn), 64'(va[31:12]));
    chk({tag, " ready low"}, 64'(req_ready), 64'd0);
    chk({tag, " no early resp"}, 64'(resp_valid), 64'd0);
    req_valid = 1'b0;
    ptw_ack   = 1'b0;
    flush     = flush_mid;
    tick();
    chk({tag, " ptw_req held"}, 64'(ptw_req), 64'd1);
    flush     = 1'b0;
    ptw_ack   = 1'b1;
    ptw_ppn   = ppn;
    ptw_perm  = perm;
    ptw_fault = fault;
    tick();
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, " paddr"}, 64'(resp_paddr), 64'(exp_pa));
    chk({tag, " exc"}, 64'(exc), 64'(exp_exc));
    chk({tag, " ptw_req drop"}, 64'(ptw_req), 64'd0);
    chk({tag, " state resp"}, 64'(dbg_state), 64'(ST_RESP));
    ptw_ack   = 1'b0;
    ptw_fault = 1'b0;
    tick();
    chk({tag, " resp pulse end"}, 64'(resp_valid), 64'd0);
    chk({tag, " ready back"}, 64'(req_ready), 64'd1);
  endtask

  // Hit: response in the next cycle, no walk. Calls chain back-to-back.
  task automatic do_hit(input string tag, input logic [31:0] va, input logic [1:0] ty,
                        input logic [1:0] sz, input logic flush_same,
                        input logic [31:0] exp_pa, input logic [7:0] exp_exc);
    drive_req(va, ty, sz);
    flush = flush_same;
    exp_hits++;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, " paddr"}, 64'(resp_paddr), 64'(exp_pa));
    chk({tag, " exc"}, 64'(exc), 64'(exp_exc));
    chk({tag, " no walk"}, 64'(ptw_req), 64'd0);
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic do_misalign(input string tag, input logic [31:0] va, input logic [1:0] ty,
                             input logic [1:0] sz, input logic [7:0] exp_exc);
    drive_req(va, ty, sz);
    tick();
    req_valid = 1'b0;
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, " paddr"}, 64'(resp_paddr), 64'd0);
    chk({tag, " exc"}, 64'(exc), 64'(exp_exc));
    tick();
    chk({tag, " no walk"}, 64'(ptw_req), 64'd0);
    chk({tag, " single pulse"}, 64'(resp_valid), 64'd0);
  endtask

  // Directed sequence
  initial begin
    n_total    = 0;
    n_bad      = 0;
    exp_hits   = 0;
    exp_misses = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_vaddr  = '0;
    req_size   = '0;
    req_type   = '0;
    flush      = 1'b0;
    ptw_ack    = 1'b0;
    ptw_ppn    = '0;
    ptw_perm   = '0;
    ptw_fault  = 1'b0;

    #23;
    chk("reset ready", 64'(req_ready), 64'd1);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset ptw_req", 64'(ptw_req), 64'd0);
    chk("reset paddr", 64'(resp_paddr), 64'd0);
    chk("reset exc", 64'(exc), 64'd0);
    chk("reset ptw_vpn", 64'(ptw_vpn), 64'd0);
    chk("reset state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    tick();

    // Cold miss, then hits on the R-only page
    do_miss("cold", 32'h0000_1234, 2'd0, 2'd2, 20'h00080, 3'b001, 1'b0, 1'b0,
            32'h0008_0234, 8'd0);
    do_hit("ld hit", 32'h0000_1234, 2'd0, 2'd2, 1'b0, 32'h0008_0234, 8'd0);
    do_hit("st pf", 32'h0000_1234, 2'd1, 2'd2, 1'b0, 32'h0, 8'd15);
    do_hit("inst pf", 32'h0000_1000, 2'd2, 2'd2, 1'b0, 32'h0, 8'd12);

    // Misalignment
    do_misalign("ld mis", 32'h0000_1002, 2'd0, 2'd2, 8'd4);
    do_misalign("st mis", 32'h0000_1004, 2'd1, 2'd3, 8'd6);

    // Walker fault (no fill), then the real fill of VPN 2
    do_miss("ptw fault", 32'h0000_2000, 2'd0, 2'd0, 20'h0, 3'b000, 1'b1, 1'b0,
            32'h0, 8'd13);
    do_miss("fill v2", 32'h0000_2010, 2'd0, 2'd2, 20'h00102, 3'b111, 1'b0, 1'b0,
            32'h0010_2010, 8'd0);
    do_hit("st hit v2", 32'h0000_2010, 2'd1, 2'd2, 1'b0, 32'h0010_2010, 8'd0);
    do_hit("inst hit v2", 32'h0000_2004, 2'd2, 2'd3, 1'b0, 32'h0010_2004, 8'd0);

    // Fill VPNs 3..9: entries 2..7 fill, then the ninth fill replaces entry 0
    for (int k = 3; k <= 9; k++) begin
      do_miss("fill loop", (32'(k) << 12) | 32'h10, 2'd0, 2'd2, 20'h00100 + 20'(k),
              3'b111, 1'b0, 1'b0, ((32'h100 + 32'(k)) << 12) | 32'h10, 8'd0);
    end
    do_hit("hit v9", 32'h0000_9010, 2'd0, 2'd2, 1'b0, 32'h0010_9010, 8'd0);
    do_hit("hit v2 kept", 32'h0000_2010, 2'd0, 2'd2, 1'b0, 32'h0010_2010, 8'd0);
    do_miss("v1 evicted", 32'h0000_1234, 2'd0, 2'd2, 20'h000AA, 3'b001, 1'b0, 1'b0,
            32'h000A_A234, 8'd0);

    // Flush during a walk: response delivered, fill suppressed
    do_miss("flush walk", 32'h0000_A010, 2'd0, 2'd2, 20'h0010A, 3'b001, 1'b0, 1'b1,
            32'h0010_A010, 8'd0);
    do_miss("after flush", 32'h0000_A010, 2'd0, 2'd2, 20'h0010A, 3'b001, 1'b0, 1'b0,
            32'h0010_A010, 8'd0);
    do_hit("hit in flush", 32'h0000_A010, 2'd0, 2'd2, 1'b1, 32'h0010_A010, 8'd0);
    do_miss("flushed", 32'h0000_A010, 2'd0, 2'd2, 20'h0020A, 3'b001, 1'b0, 1'b0,
            32'h0020_A010, 8'd0);

`ifdef TLB_PERF_COUNTERS_EN
    chk("hit count", 64'(hit_count), 64'(exp_hits));
    chk("miss count", 64'(miss_count), 64'(exp_misses));
`endif

    // Reset while the walker request is outstanding
    drive_req(32'h0000_B000, 2'd0, 2'd2);
    tick();
    req_valid = 1'b0;
    chk("rst walk ptw_req", 64'(ptw_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst async ptw_req", 64'(ptw_req), 64'd0);
    chk("rst async resp", 64'(resp_valid), 64'd0);
    ptw_ack  = 1'b1;
    ptw_ppn  = 20'h000BB;
    ptw_perm = 3'b001;
    tick();
    tick();
    chk("rst held resp", 64'(resp_valid), 64'd0);
    ptw_ack = 1'b0;
    reset   = 1'b1;
    tick();
    chk("rst rel ready", 64'(req_ready), 64'd1);
    chk("rst rel resp", 64'(resp_valid), 64'd0);
    chk("rst rel ptw_req", 64'(ptw_req), 64'd0);
    do_miss("post reset", 32'h0000_1234, 2'd0, 2'd2, 20'h00080, 3'b001, 1'b0, 1'b0,
            32'h0008_0234, 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

Synthesizable successor to the simulation-only translation model: a parametrised, fully-associative TLB with a miss-handling FSM and an external page-table-walker handshake. It sits between the LSU/fetch address generation and the cache, translates one virtual address per cycle on a hit, and reports load, store and fetch misalignment and page faults as an 8-bit exception code, with 0 meaning no exception.

## Interface
Parameters:
- VADDR_W, 32, virtual address width
- PADDR_W, 32, physical address width
- PAGE_OFFSET_W, 12, page offset bits, i.e. 4 KiB pages
- NUM_ENTRIES, 8, TLB entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid_i  in  1  translation request
- req_ready_o  out  1  block can accept a request
- req_vaddr_i  in  VADDR_W  virtual address
- req_size_i  in  2  log2 of access bytes: 1, 2, 4 or 8 bytes
- req_type_i  in  2  access type: LD=0, ST=1, INST=2
- resp_valid_o  out  1  one-cycle response strobe
- resp_paddr_o  out  PADDR_W  physical address
- exception_o  out  8  exception code; 0 means none
- flush_i  in  1  invalidate all entries
- ptw_req_o  out  1  walk request, held until acknowledged
- ptw_vpn_o  out  VADDR_W-PAGE_OFFSET_W  VPN to walk
- ptw_ack_i  in  1  walk done; data valid this cycle
- ptw_ppn_i  in  PADDR_W-PAGE_OFFSET_W  returned PPN
- ptw_perm_i  in  3  permissions: {X, W, R}
- ptw_fault_i  in  1  no valid mapping

## Operation
- Entry fields: valid, VPN, PPN, R, W, X.
- Lookup compares the request VPN against all valid entries. At most one entry matches, because fills never duplicate a VPN.
- Misalignment check:
  - Applies when the address is not a multiple of 2^req_size_i.
  - LD reports 4 and ST reports 6. INST is not checked.
  - No lookup and no walk are performed.
- Permission check on a hit:
  - LD requires R, ST requires W, INST requires X.
  - On failure the page-fault code is reported: LD 13, ST 15, INST 12.
  - resp_paddr_o is 0 whenever exception_o is nonzero.
- FSM states: IDLE, WALK, RESP.
  - IDLE: req_ready_o is 1. On an accepted hit or misaligned request, the response is registered and the FSM stays in IDLE. On an accepted miss, the VPN, type and offset are latched and the FSM goes to WALK.
  - WALK: ptw_req_o is 1 and ptw_vpn_o carries the latched VPN. When ptw_ack_i arrives:
    - If ptw_fault_i is 1, the response is a page fault and there is no fill.
    - Otherwise the victim entry is filled and the permission check is applied to ptw_perm_i.
    - The FSM then goes to RESP.
  - RESP: resp_valid_o pulses for one cycle, then the FSM returns to IDLE.
- Replacement:
  - The victim is the lowest-index invalid entry if one exists.
  - Otherwise the victim is the round-robin pointer, which advances on every fill and wraps from NUM_ENTRIES-1 to 0.
- Flush behaviour:
  - flush_i clears all valid bits at the clock edge. A request accepted in the same cycle is looked up against the pre-flush contents.
  - A flush during WALK marks the fill as suppressed. The walk still completes and its response is still delivered.
- There is no response backpressure; the consumer must always sink resp_valid_o.

## Timing
- Reset values:
  - req_ready_o is 1 and the FSM is in IDLE.
  - resp_valid_o, ptw_req_o and every data output are 0.
  - All entries are invalid and the round-robin pointer is 0.
- Hit or misaligned request accepted in cycle T: response in T+1. Back-to-back hits sustain one per cycle.
- Miss accepted in cycle T:
  - ptw_req_o rises in T+1 and drops in the cycle after ptw_ack_i.
  - With ack in cycle A, resp_valid_o is asserted in A+1.
  - A request in A+2 sees the filled entry.
- If ptw_ack_i is asserted in the cycle of the miss acceptance, it is ignored.
- Reset asserted mid-walk aborts the walk immediately: ptw_req_o drops asynchronously and no response is issued.

## Configuration
- TLB_PERF_COUNTERS_EN:
  - Defined: adds output ports hit_count_o[31:0] and miss_count_o[31:0], both reset to 0.
  - hit_count_o increments on each accepted hit and miss_count_o on each accepted miss. Misaligned requests count as neither. The counters wrap at 2^32 and are not cleared by flush_i.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package mmu_pkg contains:
  - Exception code constants: EXC_NONE=0, LD_MISALIGN=4, ST_MISALIGN=6, INST_PF=12, LD_PF=13, ST_PF=15.
  - The access-type enum.
  - The FSM state enum.
  - The TLB entry struct.
- Sub-module tlb_cam holds the entry array, match logic, victim select and the flush clear. tlb_mmu holds the FSM, checks and response register.

## Test plan
- Cold miss: LD vaddr 0x0000_1234 with walk response PPN 0x00080, perm R -> ptw_vpn_o is 0x00001; response paddr 0x0008_0234, exc 0, in the cycle after ack.
- Same LD repeated, then ST to the same page -> the LD hits with 1-cycle latency and no ptw_req_o; the ST reports exc 15 with paddr 0.
- LD size 2 at 0x1002 -> exc 4 in T+1 and no walk; ST size 3 at 0x1004 -> exc 6.
- Nine distinct VPNs filled with NUM_ENTRIES=8 -> the ninth replaces entry 0; re-access of the first VPN misses.
- flush_i asserted during WALK -> the response is still delivered, the next access to the same VPN misses, and a hit accepted in the flush cycle still returns its translation.
- Reset asserted while ptw_req_o is 1 -> ptw_req_o drops immediately, no resp_valid_o is issued, and req_ready_o is 1 after reset releases.
